// File: rtl/bcd_stopwatch_core.sv
// Multi-digit BCD stopwatch counter with IDLE/RUN/PAUSE run control and a wrap pulse.
// Defining BCD_STOPWATCH_DOWN_EN builds the borrow logic and honours dir; otherwise count-up only.
module bcd_stopwatch_core #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                dir,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                wrap
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t              state_r;
  logic [4*DIGITS-1:0] digits_r;
  logic                running_r;
  logic                wrap_r;

  logic [4*DIGITS-1:0] next_digits_s;
  logic [3:0]          digit_s;
  logic                carry_s;
  logic                wrap_s;

`ifndef BCD_STOPWATCH_DOWN_EN
  logic                unused_dir_s;
  assign unused_dir_s = dir;
`endif

  // Ripple carry/borrow across the mod-10 digits; carry out of the top digit is the wrap.
  always_comb begin
    next_digits_s = digits_r;
    digit_s       = 4'd0;
    carry_s       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = digits_r[4*i +: 4];
      if (carry_s == 1'b0) begin
        next_digits_s[4*i +: 4] = digit_s;
      end
`ifdef BCD_STOPWATCH_DOWN_EN
      else if (dir == 1'b1) begin
        if (digit_s == 4'd0) begin
          next_digits_s[4*i +: 4] = 4'd9;
        end else begin
          next_digits_s[4*i +: 4] = digit_s - 4'd1;
          carry_s                 = 1'b0;
        end
      end
`endif
      else begin
        if (digit_s == 4'd9) begin
          next_digits_s[4*i +: 4] = 4'd0;
        end else begin
          next_digits_s[4*i +: 4] = digit_s + 4'd1;
          carry_s                 = 1'b0;
        end
      end
    end
    wrap_s = carry_s;
  end

  // Run-control FSM and count register; clear beats start_stop beats tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      digits_r  <= '0;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else if (clear) begin
      state_r   <= ST_IDLE;
      digits_r  <= '0;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      // Tick is judged against the state before this edge.
      if (tick && (state_r == ST_RUN)) begin
        digits_r <= next_digits_s;
        wrap_r   <= wrap_s;
      end else begin
        wrap_r   <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            running_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else begin
            running_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            running_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign digits  = digits_r;
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Self-checking bench for bcd_stopwatch_core: integer-valued reference model plus directed cases.
module tb_bcd_stopwatch_core;

  localparam int DIGITS = 4;
  localparam int MOD    = 10**DIGITS;
`ifdef BCD_STOPWATCH_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                tick;
  logic                start_stop;
  logic                clear;
  logic                dir;
  logic [4*DIGITS-1:0] digits;
  logic                running;
  logic                wrap;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Reference model: value as a plain integer, state 0=idle 1=run 2=pause
  int m_val;
  int m_state;
  bit m_wrap;

  bcd_stopwatch_core #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
    .clear(clear), .dir(dir), .digits(digits), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int d;
    r = '0;
    d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  function automatic int step_val(input int v, input bit down);
    if (down) return (v == 0) ? MOD - 1 : v - 1;
    return (v == MOD - 1) ? 0 : v + 1;
  endfunction

  function automatic bit step_wraps(input int v, input bit down);
    return down ? (v == 0) : (v == MOD - 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_val   <= 0;
      m_state <= 0;
      m_wrap  <= 1'b0;
    end else if (clear) begin
      m_val   <= 0;
      m_state <= 0;
      m_wrap  <= 1'b0;
    end else begin
      if (tick && m_state == 1) begin
        m_val  <= step_val(m_val, DOWN_EN && dir);
        m_wrap <= step_wraps(m_val, DOWN_EN && dir);
      end else begin
        m_wrap <= 1'b0;
      end
      if (start_stop) m_state <= (m_state == 1) ? 2 : 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en && reset) begin
      chk("model_digits",  32'(digits),  32'(to_bcd(m_val)));
      chk("model_running", 32'(running), 32'(m_state == 1));
      chk("model_wrap",    32'(wrap),    32'(m_wrap));
    end
  end

  task automatic step(input logic t, input logic s, input logic c);
    tick = t;
    start_stop = s;
    clear = c;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic restart;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    tick = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits",  32'(digits),  32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_wrap",    32'(wrap),    32'h0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Reset and run
    step(1'b0, 1'b1, 1'b0);
    ticks(12);
    chk("run12_digits",  32'(digits),  32'h0012);
    chk("run12_running", 32'(running), 32'h1);
    chk("run12_wrap",    32'(wrap),    32'h0);

    // Pause with simultaneous tick
    restart();
    ticks(5);
    step(1'b1, 1'b1, 1'b0);
    chk("pause_digits",  32'(digits),  32'h0006);
    chk("pause_running", 32'(running), 32'h0);
    ticks(3);
    chk("paused_hold", 32'(digits), 32'h0006);
    step(1'b1, 1'b1, 1'b0);
    chk("resume_digits",  32'(digits),  32'h0006);
    chk("resume_running", 32'(running), 32'h1);

    // Clear beats start_stop and tick
    restart();
    ticks(420);
    chk("pre_clear", 32'(digits), 32'h0420);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_digits",  32'(digits),  32'h0);
    chk("clear_running", 32'(running), 32'h0);
    chk("clear_wrap",    32'(wrap),    32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("idle_tick", 32'(digits), 32'h0);

    // Up wrap
    restart();
    ticks(9998);
    chk("pre_wrap", 32'(digits), 32'h9998);
    step(1'b1, 1'b0, 1'b0);
    chk("nines_digits", 32'(digits), 32'h9999);
    chk("nines_wrap",   32'(wrap),   32'h0);
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_digits", 32'(digits), 32'h0000);
    chk("wrap_pulse",  32'(wrap),   32'h1);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Down count (or ignored dir)
    restart();
    ticks(100);
    dir = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    chk("dir_step", 32'(digits), DOWN_EN ? 32'h0099 : 32'h0101);
    restart();
    step(1'b1, 1'b0, 1'b0);
    chk("dir_zero_digits", 32'(digits), DOWN_EN ? 32'h9999 : 32'h0001);
    chk("dir_zero_wrap",   32'(wrap),   DOWN_EN ? 32'h1 : 32'h0);
    dir = 1'b0;

    // Randomized phase against the model
    restart();
    for (int i = 0; i < 3000; i++) begin
      dir = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 99) == 0));
    end
    dir = 1'b0;

    // Async reset mid-count
    restart();
    ticks(733);
    chk("pre_reset", 32'(digits), 32'h0733);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_digits",  32'(digits),  32'h0);
    chk("async_running", 32'(running), 32'h0);
    chk("async_wrap",    32'(wrap),    32'h0);
    @(negedge clk);
    reset = 1'b1;
    ticks(3);
    chk("post_reset_ignored", 32'(digits), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_count",   32'(digits),  32'h0001);
    chk("post_reset_running", 32'(running), 32'h1);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_core.md
# bcd_stopwatch_core

Multi-digit BCD counter that sits directly downstream of the 1 Hz tick generator: it consumes the generator's single-cycle `tick` pulse and advances a packed BCD value that feeds the seven-segment display multiplexer. A three-state run control (IDLE/RUN/PAUSE) gates counting under a start/stop pulse and a synchronous clear. A registered wrap pulse is provided for cascading or for an alarm LED.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.

Ports:
- `clk`, input, 1: system clock (50 MHz board clock).
- `reset`, input, 1: asynchronous, active-low reset; asserted when 0.
- `tick`, input, 1: single-cycle count-enable pulse from the tick generator.
- `start_stop`, input, 1: single-cycle pulse, already synchronized and debounced upstream; toggles run state.
- `clear`, input, 1: synchronous clear, level-sensitive.
- `dir`, input, 1: 0 = count up, 1 = count down. Only used when `BCD_STOPWATCH_DOWN_EN` is defined.
- `digits`, output, 4*DIGITS: packed BCD value; digit 0 (least significant) is in bits [3:0].
- `running`, output, 1: high while in RUN.
- `wrap`, output, 1: one-cycle pulse when the count wraps.

## Operation

- States:
  - IDLE: after reset or clear; `digits` = 0.
  - RUN: counting on `tick`.
  - PAUSE: holding the value.
- Transitions on `start_stop`: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
- `clear` from any state → IDLE.
- Counting: on a clock edge where `tick`=1 and the current state is RUN, the BCD value steps by one.
- Up-count:
  - Digit 0 increments.
  - Any digit at 9 returns to 0 and carries into the next digit.
  - All-nines (e.g. 9999) → all-zeros and `wrap`=1.
- Down-count:
  - Digit 0 decrements.
  - Any digit at 0 goes to 9 and borrows from the next digit.
  - All-zeros → all-nines and `wrap`=1.
- Digits never hold 0xA–0xF. No binary-to-BCD conversion is used; each digit is a mod-10 counter with ripple carry/borrow computed combinationally within the cycle.
- Priority within one cycle: `clear` > `start_stop` > `tick`.
  - `clear` with `tick`: the tick is discarded; result is IDLE with 0.
  - `clear` with `start_stop`: result is IDLE; the toggle is discarded.
  - `start_stop` with `tick`: the tick is evaluated against the state *before* the edge.
    - RUN + both → value steps, then state becomes PAUSE.
    - PAUSE + both → no step, state becomes RUN.
- `tick` in IDLE or PAUSE is ignored.
- `dir` is sampled on the same edge as `tick`. Changing `dir` while running is legal and takes effect on the next tick.
- Reset mid-count: `digits`, state and `wrap` clear immediately and asynchronously. The count restarts from IDLE after release.

## Timing

- Reset values: `digits` = 0, `running` = 0, `wrap` = 0, state = IDLE.
- Latency:
  - `tick` at edge N → new `digits` visible after edge N (one-cycle latency).
  - `wrap` is registered and asserted in the same cycle the wrapped value appears; high for exactly one cycle.
- `running` is registered and follows the state register with no extra delay.
- Back-to-back `tick` on consecutive cycles is supported; each is counted.
- `clear` held for multiple cycles holds IDLE/0. `start_stop` is ignored while `clear`=1.
- All outputs are glitch-free registers; no combinational path from inputs to outputs.

## Configuration

- `BCD_STOPWATCH_DOWN_EN`
  - Defined: `dir` is honoured; both up-count and down-count (borrow) logic are built.
  - Undefined: count-up only; `dir` is ignored and the borrow logic is omitted; port list is unchanged.

## Test plan

Default `DIGITS`=4 unless noted.

1. Reset and run:
   - Release `reset`, pulse `start_stop`, then 12 ticks.
   - Expect `running`=1 and `digits`=16'h0012 one cycle after the 12th tick; `wrap` stays 0.
2. Up wrap:
   - Run to 16'h9998, apply 2 ticks on consecutive cycles.
   - Expect 16'h9999, then 16'h0000 with `wrap`=1 for exactly one cycle.
3. Pause and simultaneity:
   - At 16'h0005 in RUN, assert `start_stop` and `tick` in the same cycle → 16'h0006 and `running`=0.
   - Further ticks hold 16'h0006.
   - `start_stop`+`tick` again → still 16'h0006, `running`=1.
4. Clear priority:
   - At 16'h0420 in RUN, assert `clear`, `start_stop` and `tick` together.
   - Expect 16'h0000, `running`=0, `wrap`=0.
   - A following tick leaves 16'h0000.
5. Down-count (macro defined):
   - At 16'h0100 with `dir`=1, 1 tick → 16'h0099.
   - From 16'h0000, 1 tick → 16'h9999 with `wrap`=1.
   - Macro undefined: same stimulus gives 16'h0101.
6. Async reset mid-count:
   - Assert `reset`=0 between clock edges at 16'h0733.
   - Expect `digits`=0, `running`=0 immediately, without waiting for a clock edge.
   - After release, ticks are ignored until `start_stop`.
